// File: rtl/ysyx_22050039_pkg.sv
// ysyx_22050039_pkg: shared LSU op-field positions, size codes, FSM states and helpers
package ysyx_22050039_pkg;
  localparam int OP_STORE = 3;
  localparam int OP_ZEXT  = 2;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    return |(off & 3'((4'd1 << size) - 4'd1));
  endfunction
  function automatic logic [7:0] wmask(input logic [2:0] off, input logic [1:0] size);
    return 8'(((16'd1 << (4'd1 << size)) - 16'd1) << off);
  endfunction
endpackage

// File: rtl/ysyx_22050039_lsu_if.sv
// ysyx_22050039_lsu_if: EXU request, memory bus and writeback handshakes of the LSU
interface ysyx_22050039_lsu_if #(parameter int XLEN = 64, parameter int RD_W = 5);
  logic            req_valid, req_ready;
  logic [3:0]      req_op;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [RD_W-1:0] req_rd;
  logic            mem_req_valid, mem_req_ready, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rdata;
  logic            done_valid, done_ready, done_wen, done_err;
  logic [RD_W-1:0] done_rd;
  logic [XLEN-1:0] done_data;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, mem_req_ready, mem_rsp_valid, mem_rdata, done_ready,
    output req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, done_valid, done_wen, done_rd, done_data, done_err
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, mem_req_ready, mem_rsp_valid, mem_rdata, done_ready,
    input  req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, done_valid, done_wen, done_rd, done_data, done_err
  );
endinterface

// File: rtl/ysyx_22050039_ld_align.sv
// ysyx_22050039_ld_align: extracts the addressed field from a doubleword and sign/zero-extends it
module ysyx_22050039_ld_align
  import ysyx_22050039_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_zext,
  output logic [XLEN-1:0] o_data
);
  logic [XLEN-1:0] w_sh;
  logic            w_sx;
  assign w_sh = i_rdata >> {i_off, 3'b000};
  assign w_sx = !i_zext;
  always_comb
    o_data = i_size == SZ_B ? {{(XLEN-8){w_sx & w_sh[7]}}, w_sh[7:0]} :
             i_size == SZ_H ? {{(XLEN-16){w_sx & w_sh[15]}}, w_sh[15:0]} :
             i_size == SZ_W ? {{(XLEN-32){w_sx & w_sh[31]}}, w_sh[31:0]} : w_sh;
endmodule

// File: rtl/ysyx_22050039_lsu.sv
// ysyx_22050039_lsu: single-outstanding load/store unit bridging EXU to an aligned doubleword memory bus
module ysyx_22050039_lsu
  import ysyx_22050039_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input logic               clk,
  input logic               rst,
  ysyx_22050039_lsu_if.slave bus
);
  state_e          r_state;
  logic [3:0]      r_op;
  logic [2:0]      r_off;
  logic            r_mem_req_valid, r_mem_we;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata;
  logic [7:0]      r_mem_wmask;
  logic            r_done_valid, r_done_wen, r_done_err;
  logic [RD_W-1:0] r_done_rd;
  logic [XLEN-1:0] r_done_data;
  logic            w_err;
  logic [XLEN-1:0] w_ld;
  assign w_err = (bus.req_op[OP_STORE] & bus.req_op[OP_ZEXT]) | misaligned(bus.req_addr[2:0], bus.req_op[1:0]);
  ysyx_22050039_ld_align #(.XLEN(XLEN)) u_align (
    .i_rdata(bus.mem_rdata),
    .i_off  (r_off),
    .i_size (r_op[1:0]),
    .i_zext (r_op[OP_ZEXT]),
    .o_data (w_ld)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_op            <= '0;
      r_off           <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
      r_done_valid    <= 1'b0;
      r_done_wen      <= 1'b0;
      r_done_err      <= 1'b0;
      r_done_rd       <= '0;
      r_done_data     <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_op        <= bus.req_op;
          r_off       <= bus.req_addr[2:0];
          r_done_rd   <= bus.req_rd;
          r_mem_addr  <= {bus.req_addr[XLEN-1:3], 3'b000};
          r_mem_we    <= bus.req_op[OP_STORE];
          r_mem_wmask <= bus.req_op[OP_STORE] ? wmask(bus.req_addr[2:0], bus.req_op[1:0]) : 8'h00;
          r_mem_wdata <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
          // faulting ops skip the bus entirely and report straight away
          r_state         <= w_err ? DONE : REQ;
          r_mem_req_valid <= !w_err;
          r_done_valid    <= w_err;
          r_done_err      <= w_err;
          r_done_wen      <= 1'b0;
          r_done_data     <= '0;
        end
        REQ: if (bus.mem_req_ready) begin
          r_mem_req_valid <= 1'b0;
          r_state         <= WAIT;
        end
        WAIT: if (bus.mem_rsp_valid) begin
          r_state      <= DONE;
          r_done_valid <= 1'b1;
          r_done_wen   <= !r_op[OP_STORE] && r_done_rd != '0;
          r_done_data  <= r_op[OP_STORE] ? '0 : w_ld;
        end
        DONE: if (bus.done_ready) begin
          r_state      <= IDLE;
          r_done_valid <= 1'b0;
          r_done_wen   <= 1'b0;
          r_done_err   <= 1'b0;
        end
      endcase
    end
  end
  assign bus.req_ready     = r_state == IDLE && rst;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_wmask     = r_mem_wmask;
  assign bus.done_valid    = r_done_valid;
  assign bus.done_wen      = r_done_wen;
  assign bus.done_err      = r_done_err;
  assign bus.done_rd       = r_done_rd;
  assign bus.done_data     = r_done_data;
endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// tb_ysyx_22050039_lsu: directed table, randomized ops against a byte-level model, reset-in-flight sequence
module tb_ysyx_22050039_lsu;
  typedef struct {
    logic [3:0]  op;
    logic [63:0] addr, wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          ms, ds;
    logic        err, wen;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [63:0] maddr, mwdata;
    int          lat;
  } vec_t;
  typedef struct {
    logic        err, wen, mem, we;
    logic [4:0]  rd;
    logic [63:0] data, maddr, mwdata;
    logic [7:0]  mask;
    int          lat, mlat;
  } res_t;
  logic clk = 0, rst = 0;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[9];
  ysyx_22050039_lsu_if #(.XLEN(64), .RD_W(5)) bus ();
  ysyx_22050039_lsu #(.XLEN(64), .RD_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // reference: byte-by-byte view of the access, independent of shifter structure
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int bytes = 1 << v.op[1:0];
    int off = int'(v.addr % 8);
    r.err = (v.op[3] && v.op[2]) || (v.addr % bytes != 0);
    r.wen = 0; r.data = 0; r.mask = 0; r.mwdata = 0;
    r.maddr = v.addr - off;
    r.lat = r.err ? 1 : 3 + v.ms;
    if (!r.err && v.op[3]) begin
      for (int i = 0; i < bytes; i++) r.mask[off+i] = 1'b1;
      r.mwdata = v.wdata << (8 * off);
    end
    if (!r.err && !v.op[3]) begin
      for (int i = 0; i < bytes; i++) r.data[8*i +: 8] = v.rdata[8*(off+i) +: 8];
      if (!v.op[2] && r.data[8*bytes-1])
        for (int i = bytes; i < 8; i++) r.data[8*i +: 8] = 8'hFF;
      r.wen = v.rd != 0;
    end
    return r;
  endfunction
  task automatic do_op(input vec_t v, output res_t g);
    int n = 0, ms = 0, ds = 0, w = 0;
    bit hs = 0, fin = 0, dseen = 0;
    g = '{default: 0};
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1; bus.req_op = v.op; bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.req_rd = v.rd;
    @(posedge clk); #1 bus.req_valid = 0;
    while (!fin && n < 60) begin
      @(negedge clk); n++;
      bus.mem_rsp_valid = hs; bus.mem_rdata = v.rdata; hs = 0;
      chk("req_ready_busy", bus.req_ready, 0);
      if (bus.mem_req_valid) begin
        if (!g.mem) begin
          g.mem = 1; g.mlat = n; g.we = bus.mem_we; g.maddr = bus.mem_addr; g.mwdata = bus.mem_wdata; g.mask = bus.mem_wmask;
        end else begin
          chk("mem_addr_hold", bus.mem_addr, g.maddr);
          chk("mem_wdata_hold", bus.mem_wdata, g.mwdata);
          chk("mem_wmask_hold", bus.mem_wmask, g.mask);
        end
        bus.mem_req_ready = ms >= v.ms; ms++;
        // a response during the request handshake must be ignored
        if (bus.mem_req_ready) begin hs = 1; bus.mem_rsp_valid = 1; bus.mem_rdata = ~v.rdata; end
      end else bus.mem_req_ready = 0;
      if (bus.done_valid) begin
        if (!dseen) begin
          dseen = 1; g.lat = n; g.err = bus.done_err; g.wen = bus.done_wen; g.data = bus.done_data; g.rd = bus.done_rd;
        end else begin
          chk("done_data_hold", bus.done_data, g.data);
          chk("done_flags_hold", {bus.done_err, bus.done_wen, bus.done_rd}, {g.err, g.wen, g.rd});
        end
        bus.done_ready = ds >= v.ds; ds++;
        fin = bus.done_ready;
      end
    end
    if (!fin) chk("op_timeout", 0, 1);
    @(posedge clk); #1 bus.done_ready = 0; bus.mem_rsp_valid = 0; bus.mem_req_ready = 0;
  endtask
  task automatic compare(input vec_t v, input res_t g);
    chk("done_err", g.err, v.err);
    chk("done_wen", g.wen, v.wen);
    chk("done_data", g.data, v.data);
    chk("done_rd", g.rd, v.rd);
    chk("done_latency", g.lat, v.lat);
    chk("mem_req_seen", g.mem, !v.err);
    if (!v.err) begin
      chk("mem_req_latency", g.mlat, 1);
      chk("mem_addr", g.maddr, v.maddr);
      chk("mem_we", g.we, v.op[3]);
      chk("mem_wmask", g.mask, v.mask);
      if (v.op[3]) chk("mem_wdata", g.mwdata, v.mwdata);
    end
  endtask
  initial begin
    res_t g;
    vec_t v;
    bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_rd = 0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rdata = 0; bus.done_ready = 0;
    tbl[0] = '{4'b0010, 64'h8000_0004, 64'h0, 5'd5, 64'h8765_4321_0000_0000, 0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h8000_0000, 64'h0, 3};
    tbl[1] = '{4'b1000, 64'h8000_0003, 64'hAB, 5'd3, 64'h0, 0, 0, 1'b0, 1'b0, 64'h0, 8'h08, 64'h8000_0000, 64'hAB00_0000, 3};
    tbl[2] = '{4'b0001, 64'h8000_0001, 64'h0, 5'd6, 64'h0, 0, 0, 1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1};
    tbl[3] = '{4'b0010, 64'h8000_0010, 64'h0, 5'd7, 64'h0000_0000_1234_5678, 3, 2, 1'b0, 1'b1, 64'h1234_5678, 8'h00, 64'h8000_0010, 64'h0, 6};
    tbl[4] = '{4'b0100, 64'h8000_0007, 64'h0, 5'd9, 64'hF000_0000_0000_0000, 0, 0, 1'b0, 1'b1, 64'hF0, 8'h00, 64'h8000_0000, 64'h0, 3};
    tbl[5] = '{4'b0011, 64'h8000_0008, 64'h0, 5'd0, 64'h1122_3344_5566_7788, 0, 0, 1'b0, 1'b0, 64'h1122_3344_5566_7788, 8'h00, 64'h8000_0008, 64'h0, 3};
    tbl[6] = '{4'b1100, 64'h8000_0000, 64'h55, 5'd2, 64'h0, 0, 0, 1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1};
    tbl[7] = '{4'b0000, 64'h8000_0002, 64'h0, 5'd1, 64'h0000_0000_0080_0000, 0, 1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h8000_0000, 64'h0, 3};
    tbl[8] = '{4'b1011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 5'd8, 64'h0, 1, 0, 1'b0, 1'b0, 64'h0, 8'hFF, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 4};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_done_flags", {bus.done_valid, bus.done_wen, bus.done_err, bus.mem_we}, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    chk("rst_done_data", bus.done_data, 0);
    rst = 1;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i], g);
      compare(tbl[i], g);
    end
    // reset while waiting for the memory response; the late response must be dropped
    @(negedge clk);
    bus.req_valid = 1; bus.req_op = 4'b0011; bus.req_addr = 64'h8000_0100; bus.req_rd = 5'd4;
    @(posedge clk); #1 bus.req_valid = 0; bus.mem_req_ready = 1;
    @(posedge clk); #1 bus.mem_req_ready = 0;
    @(negedge clk); rst = 0;
    #1 chk("wait_rst_req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    chk("wait_rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("wait_rst_done_valid", bus.done_valid, 0);
    @(negedge clk); rst = 1; bus.mem_rsp_valid = 1; bus.mem_rdata = 64'h1234;
    #1 chk("wait_rel_req_ready", bus.req_ready, 1);
    @(posedge clk); #1 bus.mem_rsp_valid = 0;
    @(negedge clk);
    chk("late_rsp_done_valid", bus.done_valid, 0);
    chk("late_rsp_req_ready", bus.req_ready, 1);
    for (int i = 0; i < 150; i++) begin
      v = '{default: 0};
      v.op = 4'($urandom);
      v.addr = 64'h8000_0000 + 64'($urandom_range(0, 63));
      v.wdata = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.rd = 5'($urandom);
      v.ms = $urandom_range(0, 2);
      v.ds = $urandom_range(0, 2);
      v = model(v);
      do_op(v, g);
      compare(v, g);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
